// File: rtl/mux_2_arbiter_if.sv
// Bundle for the two-requester arbitrated mux.
//   master : requester side, which drives req0/req1 and in0/in1 and observes the results
//   slave  : arbiter side, which drives gnt0/gnt1, sel, f, f_valid and busy
//   req0, req1 : access requests, held high until the requester is done
//   in0, in1   : requester data, WIDTH bits each
//   gnt0, gnt1 : registered grants, one-hot or zero
//   sel        : registered mux select (0 = in0, 1 = in1)
//   f, f_valid : registered selected data and its valid flag
//   busy       : high while any grant is active
interface mux_2_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] f;
    logic             f_valid;
    logic             busy;

    modport master (
        output req0, req1, in0, in1,
        input  gnt0, gnt1, sel, f, f_valid, busy
    );

    modport slave (
        input  req0, req1, in0, in1,
        output gnt0, gnt1, sel, f, f_valid, busy
    );
endinterface

// File: rtl/mux_2_arbiter.sv
// Two-requester arbiter that feeds a registered data mux.
// Ties are broken in favour of the requester that was not served last.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : mux_2_arbiter_if.slave, carrying the requests, data, grants, select, f/f_valid and busy
// Parameters:
//   WIDTH    : width of each data path
//   MAX_HOLD : maximum consecutive grant cycles while the other side waits (legal range 2..255)
// Optional macro MUX_2_ARBITER_TIMEOUT_EN:
//   enables the hold counter, which forces a handover once MAX_HOLD cycles have elapsed.
//   Without it, a grant lasts until its request drops.
module mux_2_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_2_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state;
    state_t nxt;
    logic   last;      // 1: requester 1 was served last, so requester 0 wins the next tie
    logic   timeout;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
        $error("mux_2_arbiter: MAX_HOLD out of range 2..255");
    end

`ifdef MUX_2_ARBITER_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    logic [7:0] hold;
    assign timeout = (hold == HOLD_LIM);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) nxt = last ? GRANT0 : GRANT1;
                else if (bus.req0)        nxt = GRANT0;
                else if (bus.req1)        nxt = GRANT1;
            end
            GRANT0: begin
                if (!bus.req0)                nxt = bus.req1 ? GRANT1 : IDLE;
                else if (timeout && bus.req1) nxt = GRANT1;
            end
            GRANT1: begin
                if (!bus.req1)                nxt = bus.req0 ? GRANT0 : IDLE;
                else if (timeout && bus.req0) nxt = GRANT0;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.busy    <= 1'b0;
            bus.sel     <= 1'b0;
            bus.f       <= '0;
            bus.f_valid <= 1'b0;
`ifdef MUX_2_ARBITER_TIMEOUT_EN
            hold        <= '0;
`endif
        end else begin
            state    <= nxt;
            bus.gnt0 <= (nxt == GRANT0);
            bus.gnt1 <= (nxt == GRANT1);
            bus.busy <= (nxt != IDLE);

            // sel keeps its last value while IDLE
            if (nxt == GRANT0) bus.sel <= 1'b0;
            else if (nxt == GRANT1) bus.sel <= 1'b1;

            if (nxt == GRANT0 && state != GRANT0) last <= 1'b0;
            if (nxt == GRANT1 && state != GRANT1) last <= 1'b1;

            // The data stage trails the grant by one cycle: it captures the input
            // selected by the grant that is currently active, and f_valid follows
            // the registered busy flag, so f and f_valid stay aligned.
            unique case (state)
                GRANT0:  bus.f <= bus.in0;
                GRANT1:  bus.f <= bus.in1;
                default: ;
            endcase
            bus.f_valid <= bus.busy;

`ifdef MUX_2_ARBITER_TIMEOUT_EN
            // Clear on any state change, and also on an expiry with no contender.
            if (nxt != state || nxt == IDLE || timeout) hold <= '0;
            else                                        hold <= hold + 8'd1;
`endif
        end
    end
endmodule
